// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and constants for the SRAM data-memory controller
//
// Purpose: state encoding, default address base and external data width used by
//          the controller, its bus interface and the behavioural SRAM model.
// Ports:   none (package).
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // ARM byte address that maps to SRAM word 0.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Width of the external asynchronous SRAM data bus.
    localparam int SRAM_DW = 16;

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage request/response bus between datapath and SRAM controller
//
// Purpose: bundles the MEM-stage access request and the controller response.
// Signals: rd_en, wr_en      access request (write wins when both are high)
//          address           32-bit byte address (ALU result)
//          write_data        32-bit store data
//          read_data         32-bit loaded word
//          ready             0 = freeze the pipeline
// Modports: master (MEM stage side), slave (controller side).
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/sram_model.sv
// rtl/sram_model.sv - behavioural 2^AW x 16 asynchronous SRAM for simulation
//
// Purpose: stands in for the external SRAM chip. Reads are combinational while
//          oe_n is low and we_n is high. A write lands once we_n has been held
//          low on the same address for MIN_WP consecutive clocks, modelling the
//          minimum write-pulse width: a strobe cut short (e.g. by a controller
//          reset) leaves the location untouched.
// Ports:   clk   sampling clock for the write-pulse timer
//          addr  halfword address
//          dq    bidirectional 16-bit data bus
//          we_n  active-low write strobe
//          oe_n  active-low output enable
module sram_model
    import sram_controller_pkg::*;
#(
    parameter int AW     = 18,
    parameter int MIN_WP = 2
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    inout  wire  [SRAM_DW-1:0] dq,
    input  logic               we_n,
    input  logic               oe_n
);

    localparam logic [7:0] MIN_WP_CNT = 8'(MIN_WP);

    logic [SRAM_DW-1:0] mem [2**AW];
    logic [AW-1:0]      wp_addr;
    logic [7:0]         wp_cnt;

    assign dq = (!oe_n && we_n) ? mem[addr] : {SRAM_DW{1'bz}};

    // wp_cnt counts consecutive low-strobe clocks on one address; the write
    // commits on the clock that completes the minimum pulse.
    always_ff @(posedge clk) begin
        if (!we_n) begin
            wp_addr <= addr;
            if (wp_cnt != 8'd0 && wp_addr == addr) begin
                if (wp_cnt != 8'hFF) begin
                    wp_cnt <= wp_cnt + 8'd1;
                end
                if (wp_cnt + 8'd1 == MIN_WP_CNT) begin
                    mem[addr] <= dq;
                end
            end else begin
                wp_cnt <= 8'd1;
                if (MIN_WP_CNT == 8'd1) begin
                    mem[addr] <= dq;
                end
            end
        end else begin
            wp_cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage data memory controller for a 16-bit asynchronous SRAM
//
// Purpose: moves each 32-bit word as two 16-bit halves (low then high), each
//          held on the SRAM bus for WAIT_CYCLES clocks, and stalls the pipeline
//          through bus.ready while an access is in flight.
// Ports:   clk        system clock
//          rst        synchronous active-high reset
//          bus        slave side of the MEM-stage request/response bus
//          sram_addr  halfword address to the SRAM
//          sram_dq    bidirectional SRAM data bus
//          sram_we_n  active-low write strobe
//          sram_oe_n  active-low output enable
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int            CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_CYCLES - 1);

    state_t             state;
    logic [CW-1:0]      counter;
    logic               is_write;
    logic [SRAM_DW-1:0] wdata_hi;
    logic [SRAM_DW-1:0] dq_out;
    logic               dq_en;
    logic               req;
    logic [31:0]        offset;
    logic               unused_offset_bits;

    assign req    = bus.rd_en | bus.wr_en;
    assign offset = bus.address - BASE_ADDR;

    // Byte offset bits [1:0] and anything above the SRAM word range are
    // dropped, so out-of-range addresses wrap silently.
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // Combinational so a request freezes the pipeline in the cycle it appears.
    assign bus.ready = (state == DONE) || (state == IDLE && !req);

    assign sram_dq = dq_en ? dq_out : {SRAM_DW{1'bz}};

    // Bus outputs are registered on the transition into each phase so they are
    // stable for the whole phase; the halfword address only toggles bit 0
    // between LO and HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            counter       <= '0;
            is_write      <= 1'b0;
            wdata_hi      <= '0;
            dq_out        <= '0;
            dq_en         <= 1'b0;
            bus.read_data <= '0;
            sram_addr     <= '0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        counter   <= '0;
                        is_write  <= bus.wr_en;
                        wdata_hi  <= bus.write_data[31:16];
                        dq_out    <= bus.write_data[15:0];
                        dq_en     <= bus.wr_en;
                        sram_addr <= {offset[SRAM_AW:2], 1'b0};
                        sram_we_n <= !bus.wr_en;
                        sram_oe_n <= bus.wr_en;
                    end
                end
                LO: begin
                    if (counter == LAST_COUNT) begin
                        state        <= HI;
                        counter      <= '0;
                        sram_addr[0] <= 1'b1;
                        dq_out       <= wdata_hi;
                        if (!is_write) begin
                            bus.read_data[15:0] <= sram_dq;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                HI: begin
                    if (counter == LAST_COUNT) begin
                        state     <= DONE;
                        counter   <= '0;
                        dq_en     <= 1'b0;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!is_write) begin
                            bus.read_data[31:16] <= sram_dq;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with behavioural SRAM
module tb_sram_controller;

    localparam int W0 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    logic [17:0] sram_addr0, sram_addr1;
    wire  [15:0] sram_dq0, sram_dq1;
    logic        we0, oe0, we1, oe1;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W0), .SRAM_AW(18)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sram_addr(sram_addr0),
        .sram_dq(sram_dq0), .sram_we_n(we0), .sram_oe_n(oe0)
    );
    sram_model #(.AW(18), .MIN_WP(W0)) u_sram0 (
        .clk(clk), .addr(sram_addr0), .dq(sram_dq0), .we_n(we0), .oe_n(oe0)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sram_addr(sram_addr1),
        .sram_dq(sram_dq1), .sram_we_n(we1), .sram_oe_n(oe1)
    );
    sram_model #(.AW(18), .MIN_WP(1)) u_sram1 (
        .clk(clk), .addr(sram_addr1), .dq(sram_dq1), .we_n(we1), .oe_n(oe1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an access started at request cycle 0 spends
    // cycles 1..W in the low half, W+1..2W in the high half, and 2W+1 in DONE.
    int          pos = -1;
    bit          m_w;
    logic [17:0] m_half;
    logic [31:0] m_wdata;
    logic [31:0] m_rd = 32'd0;
    logic [15:0] exp_mem [int];
    bit          chk_en = 1'b0;

    always @(negedge clk) begin
        bit req;
        bit e_ready;
        req     = bus0.rd_en | bus0.wr_en;
        e_ready = (pos == 2 * W0) || (pos == -1 && !req);
        if (chk_en) begin
            check("ready", 32'(bus0.ready), 32'(e_ready));
            if (e_ready) check("read_data", bus0.read_data, m_rd);
            if (pos >= 0 && pos < 2 * W0) begin
                check("sram_addr", 32'(sram_addr0), 32'(m_half) + ((pos >= W0) ? 32'd1 : 32'd0));
                check("we_n", 32'(we0), 32'(!m_w));
                check("oe_n", 32'(oe0), 32'(m_w));
                if (m_w) check("sram_dq", 32'(sram_dq0), 32'((pos < W0) ? m_wdata[15:0] : m_wdata[31:16]));
            end else begin
                check("we_n idle", 32'(we0), 32'd1);
                check("oe_n idle", 32'(oe0), 32'd1);
            end
        end
        if (rst) begin
            pos  = -1;
            m_rd = 32'd0;
        end else if (pos == -1) begin
            if (req) begin
                m_w     = bus0.wr_en;
                m_half  = 18'(((bus0.address - 32'd1024) >> 2) * 2);
                m_wdata = bus0.write_data;
                pos     = 0;
            end
        end else if (pos == 2 * W0) begin
            pos = -1;
        end else begin
            if (pos == W0 - 1 && m_w) exp_mem[int'(m_half)] = m_wdata[15:0];
            if (pos == 2 * W0 - 1) begin
                if (m_w) exp_mem[int'(m_half) + 1] = m_wdata[31:16];
                else     m_rd = {exp_mem[int'(m_half) + 1], exp_mem[int'(m_half)]};
            end
            pos++;
        end
    end

    int          lo_cnt;
    logic [31:0] done_rd;
    logic [17:0] addr_trace [16];
    logic        oe_trace   [16];

    task automatic drive(input int sel, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.rd_en = r; bus0.wr_en = w; bus0.address = a; bus0.write_data = d;
        end else begin
            bus1.rd_en = r; bus1.wr_en = w; bus1.address = a; bus1.write_data = d;
        end
    endtask

    // One access: counts the ready-low cycles from the request cycle, records
    // the bus address/oe per cycle, and drops the request after DONE.
    task automatic access(input int sel, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        drive(sel, r, w, a, d);
        lo_cnt = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (c < 16) begin
                addr_trace[c] = (sel == 0) ? sram_addr0 : sram_addr1;
                oe_trace[c]   = (sel == 0) ? oe0 : oe1;
            end
            if (((sel == 0) ? bus0.ready : bus1.ready) == 1'b1) begin
                seen    = 1'b1;
                done_rd = (sel == 0) ? bus0.read_data : bus1.read_data;
            end else begin
                lo_cnt++;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL access timeout: got no ready expected ready within 40 cycles");
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, a, d);
    endtask

    int          hi_cycles [$];
    logic [31:0] b2b_rd    [$];

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset ready", 32'(bus0.ready), 32'd1);
        check("reset read_data", bus0.read_data, 32'd0);
        check("reset sram_addr", 32'(sram_addr0), 32'd0);
        check("reset we_n", 32'(we0), 32'd1);
        check("reset oe_n", 32'(oe0), 32'd1);
        check("reset read_data w1", bus1.read_data, 32'd0);

        access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        check("write latency", 32'(lo_cnt), 32'd5);
        check("mem0", 32'(u_sram0.mem[0]), 32'h0000BEEF);
        check("mem1", 32'(u_sram0.mem[1]), 32'h0000DEAD);
        check("model mem0", 32'(exp_mem[0]), 32'h0000BEEF);

        access(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        check("read latency", 32'(lo_cnt), 32'd5);
        check("read DEADBEEF", done_rd, 32'hDEADBEEF);

        access(0, 1'b0, 1'b1, 32'd1032, 32'h12345678);
        check("map LO addr", 32'(addr_trace[1]), 32'd4);
        check("map HI addr", 32'(addr_trace[3]), 32'd5);
        check("mem4", 32'(u_sram0.mem[4]), 32'h00005678);
        check("mem5", 32'(u_sram0.mem[5]), 32'h00001234);

        access(0, 1'b1, 1'b0, 32'd1035, 32'd0);
        check("read 1035", done_rd, 32'h12345678);
        check("1035 LO addr", 32'(addr_trace[1]), 32'd4);

        access(0, 1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
        check("both mem2", 32'(u_sram0.mem[2]), 32'h0000F00D);
        check("both mem3", 32'(u_sram0.mem[3]), 32'h0000CAFE);
        check("both read_data kept", done_rd, 32'h12345678);
        check("both oe_n LO", 32'(oe_trace[1]), 32'd1);

        access(0, 1'b0, 1'b1, 32'd1040, 32'h11112222);

        // Reset in the first HI cycle of a write.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'd1040, 32'hA5A55A5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst-cycle we_n", 32'(we0), 32'd0);
        check("rst-cycle addr", 32'(sram_addr0), 32'd9);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd1040, 32'd0);
        @(negedge clk);
        check("post-rst ready", 32'(bus0.ready), 32'd1);
        check("post-rst we_n", 32'(we0), 32'd1);
        check("post-rst read_data", bus0.read_data, 32'd0);
        check("post-rst mem8", 32'(u_sram0.mem[8]), 32'h00005A5A);
        check("post-rst mem9", 32'(u_sram0.mem[9]), 32'h00001111);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd1040, 32'd0);
        @(negedge clk);
        check("post-rst req ready", 32'(bus0.ready), 32'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (bus0.ready) begin
                    seen    = 1'b1;
                    done_rd = bus0.read_data;
                end
            end
            check("post-rst read done", 32'(seen), 32'd1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("post-rst read 1040", done_rd, 32'h11115A5A);

        // Three back-to-back reads; address changes mid-access are ignored.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd1024, 32'd0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (bus0.ready) begin
                hi_cycles.push_back(c);
                b2b_rd.push_back(bus0.read_data);
            end
            @(posedge clk); #1;
            if (c == 1) bus0.address = 32'd1032;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("b2b ready count", 32'(hi_cycles.size()), 32'd3);
        if (hi_cycles.size() == 3) begin
            check("b2b first done", 32'(hi_cycles[0]), 32'd5);
            check("b2b spacing 1", 32'(hi_cycles[1] - hi_cycles[0]), 32'd6);
            check("b2b spacing 2", 32'(hi_cycles[2] - hi_cycles[1]), 32'd6);
            check("b2b read 1", b2b_rd[0], 32'hDEADBEEF);
            check("b2b read 2", b2b_rd[1], 32'h12345678);
            check("b2b read 3", b2b_rd[2], 32'h12345678);
        end

        // WAIT_CYCLES = 1 instance.
        access(1, 1'b0, 1'b1, 32'd1024, 32'h0BADCAFE);
        check("w1 write latency", 32'(lo_cnt), 32'd3);
        access(1, 1'b1, 1'b0, 32'd1024, 32'd0);
        check("w1 read latency", 32'(lo_cnt), 32'd3);
        check("w1 read data", done_rd, 32'h0BADCAFE);
        check("w1 LO addr", 32'(addr_trace[1]), 32'd0);
        check("w1 HI addr", 32'(addr_trace[2]), 32'd1);
        check("w1 LO oe_n", 32'(oe_trace[1]), 32'd0);
        check("w1 HI oe_n", 32'(oe_trace[2]), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
